axil_bus_demux: RTL

Single-clock AXI4-Lite 1-to-NUM_M address-decoding bridge, the parametrised successor of the two-port `bus` block. One upstream slave port `s0` is fanned out to NUM_M downstream master ports by an address-field decode. Unmapped addresses return DECERR locally. Independent write and read engines each keep one transaction outstanding, so a read may overlap a write.

---
 rtl/axil_pkg.sv | 30 +++
 rtl/axil_addr_decode.sv | 24 ++
 rtl/axil_bus_demux.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and the address-field decode used by the AXI4-Lite bus demux.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned DEC_ADDR_W = 64;
  localparam int unsigned DEC_IDX_W  = 32;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} rd_state_e;

  typedef struct packed {
    logic                 hit;
    logic [DEC_IDX_W-1:0] idx;
  } dec_result_t;

  // Select field is addr[selLsb +: selW]; indices at or beyond numM are unmapped.
  function automatic dec_result_t decodeAddr(input logic [DEC_ADDR_W-1:0] addr,
                                             input int unsigned selLsb,
                                             input int unsigned selW,
                                             input int unsigned numM);
    dec_result_t res;
    res.idx = DEC_IDX_W'((addr >> selLsb) & ((DEC_ADDR_W'(1) << selW) - DEC_ADDR_W'(1)));
    res.hit = (res.idx < numM);
    return res;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational port decode of one AXI4-Lite address channel.
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_M      = 4,
  parameter int unsigned SEL_LSB    = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [SEL_W-1:0]      idx_o
);

  dec_result_t res;

  always_comb begin
    res = decodeAddr(DEC_ADDR_W'(addr_i), SEL_LSB, SEL_W, NUM_M);
  end

  assign hit_o = res.hit;
  assign idx_o = SEL_W'(res.idx);

endmodule

// File: rtl/axil_bus_demux.sv
// AXI4-Lite 1-to-NUM_M address-decoding bridge with independent write and read engines.
module axil_bus_demux
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_M      = 4,
  parameter int unsigned SEL_LSB    = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [1:0]                     s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [1:0]                     s0_axi_rresp,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [NUM_M-1:0]               m_axi_awvalid,
  input  logic [NUM_M-1:0]               m_axi_awready,
  output logic [NUM_M*DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [NUM_M*DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic [NUM_M-1:0]               m_axi_wvalid,
  input  logic [NUM_M-1:0]               m_axi_wready,
  input  logic [NUM_M*2-1:0]             m_axi_bresp,
  input  logic [NUM_M-1:0]               m_axi_bvalid,
  output logic [NUM_M-1:0]               m_axi_bready,
  output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [NUM_M-1:0]               m_axi_arvalid,
  input  logic [NUM_M-1:0]               m_axi_arready,
  input  logic [NUM_M*DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [NUM_M*2-1:0]             m_axi_rresp,
  input  logic [NUM_M-1:0]               m_axi_rvalid,
  output logic [NUM_M-1:0]               m_axi_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  wr_state_e               wState_q;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [STRB_W-1:0]       wStrb_q;
  logic                    awGot_q, wGot_q, awHit_q;
  logic [SEL_W-1:0]        wIdx_q;
  logic                    awReady_q, wReady_q, bValid_q;
  logic [1:0]              bResp_q;
  logic [NUM_M-1:0]        mAwValid_q, mWValid_q, mBReady_q;

  rd_state_e               rState_q;
  logic [ADDR_WIDTH-1:0]   arAddr_q;
  logic [SEL_W-1:0]        rIdx_q;
  logic                    arReady_q, rValid_q;
  logic [DATA_WIDTH-1:0]   rData_q;
  logic [1:0]              rResp_q;
  logic [NUM_M-1:0]        mArValid_q, mRReady_q;

  logic                    awDecHit, arDecHit;
  logic [SEL_W-1:0]        awDecIdx, arDecIdx;

  axil_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_M(NUM_M), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W)
  ) awDecode (
    .addr_i(s0_axi_awaddr), .hit_o(awDecHit), .idx_o(awDecIdx)
  );

  axil_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_M(NUM_M), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W)
  ) arDecode (
    .addr_i(s0_axi_araddr), .hit_o(arDecHit), .idx_o(arDecIdx)
  );

  // AW and W may complete in either order; the decode is taken from whichever cycle saw AW.
  logic             awFire, wFire, awDone, wDone, selHit;
  logic [SEL_W-1:0] selIdx;
  logic             mAwPending, mWPending;

  assign awFire     = s0_axi_awvalid && awReady_q;
  assign wFire      = s0_axi_wvalid && wReady_q;
  assign awDone     = awGot_q || awFire;
  assign wDone      = wGot_q || wFire;
  assign selHit     = awGot_q ? awHit_q : awDecHit;
  assign selIdx     = awGot_q ? wIdx_q : awDecIdx;
  assign mAwPending = mAwValid_q[wIdx_q] && !m_axi_awready[wIdx_q];
  assign mWPending  = mWValid_q[wIdx_q] && !m_axi_wready[wIdx_q];

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wState_q   <= W_IDLE;
      awAddr_q   <= '0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      awGot_q    <= 1'b0;
      wGot_q     <= 1'b0;
      awHit_q    <= 1'b0;
      wIdx_q     <= '0;
      awReady_q  <= 1'b0;
      wReady_q   <= 1'b0;
      bValid_q   <= 1'b0;
      bResp_q    <= '0;
      mAwValid_q <= '0;
      mWValid_q  <= '0;
      mBReady_q  <= '0;
    end else begin
      case (wState_q)
        W_IDLE: begin
          if (awFire) begin
            awAddr_q <= s0_axi_awaddr;
            awHit_q  <= awDecHit;
            wIdx_q   <= awDecIdx;
            awGot_q  <= 1'b1;
          end
          if (wFire) begin
            wData_q <= s0_axi_wdata;
            wStrb_q <= s0_axi_wstrb;
            wGot_q  <= 1'b1;
          end
          if (awDone && wDone) begin
            awGot_q   <= 1'b0;
            wGot_q    <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            if (selHit) begin
              mAwValid_q <= NUM_M'(1) << selIdx;
              mWValid_q  <= NUM_M'(1) << selIdx;
              wState_q   <= W_FWD;
            end else begin
              bResp_q  <= RESP_DECERR;
              bValid_q <= 1'b1;
              wState_q <= W_RESP;
            end
          end else begin
            awReady_q <= !awDone;
            wReady_q  <= !wDone;
          end
        end
        W_FWD: begin
          if (mAwValid_q[wIdx_q] && m_axi_awready[wIdx_q]) mAwValid_q <= '0;
          if (mWValid_q[wIdx_q] && m_axi_wready[wIdx_q]) mWValid_q <= '0;
          if (!mAwPending && !mWPending) begin
            mBReady_q <= NUM_M'(1) << wIdx_q;
            wState_q  <= W_WAITB;
          end
        end
        W_WAITB: begin
          if (m_axi_bvalid[wIdx_q]) begin
            mBReady_q <= '0;
            bResp_q   <= m_axi_bresp[wIdx_q*2 +: 2];
            bValid_q  <= 1'b1;
            wState_q  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s0_axi_bready) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
            wState_q  <= W_IDLE;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  logic arFire;
  assign arFire = s0_axi_arvalid && arReady_q;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      rState_q   <= R_IDLE;
      arAddr_q   <= '0;
      rIdx_q     <= '0;
      arReady_q  <= 1'b0;
      rValid_q   <= 1'b0;
      rData_q    <= '0;
      rResp_q    <= '0;
      mArValid_q <= '0;
      mRReady_q  <= '0;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (arFire) begin
            arReady_q <= 1'b0;
            arAddr_q  <= s0_axi_araddr;
            rIdx_q    <= arDecIdx;
            if (arDecHit) begin
              mArValid_q <= NUM_M'(1) << arDecIdx;
              rState_q   <= R_FWD;
            end else begin
              rData_q  <= '0;
              rResp_q  <= RESP_DECERR;
              rValid_q <= 1'b1;
              rState_q <= R_RESP;
            end
          end else begin
            arReady_q <= 1'b1;
          end
        end
        R_FWD: begin
          if (m_axi_arready[rIdx_q]) begin
            mArValid_q <= '0;
            mRReady_q  <= NUM_M'(1) << rIdx_q;
            rState_q   <= R_WAITR;
          end
        end
        R_WAITR: begin
          if (m_axi_rvalid[rIdx_q]) begin
            mRReady_q <= '0;
            rData_q   <= m_axi_rdata[rIdx_q*DATA_WIDTH +: DATA_WIDTH];
            rResp_q   <= m_axi_rresp[rIdx_q*2 +: 2];
            rValid_q  <= 1'b1;
            rState_q  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s0_axi_rready) begin
            rValid_q  <= 1'b0;
            arReady_q <= 1'b1;
            rState_q  <= R_IDLE;
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  // Payload is broadcast to every port; only the selected port's valid qualifies it.
  assign s0_axi_awready = awReady_q;
  assign s0_axi_wready  = wReady_q;
  assign s0_axi_bresp   = bResp_q;
  assign s0_axi_bvalid  = bValid_q;
  assign s0_axi_arready = arReady_q;
  assign s0_axi_rdata   = rData_q;
  assign s0_axi_rresp   = rResp_q;
  assign s0_axi_rvalid  = rValid_q;
  assign m_axi_awaddr   = {NUM_M{awAddr_q}};
  assign m_axi_awvalid  = mAwValid_q;
  assign m_axi_wdata    = {NUM_M{wData_q}};
  assign m_axi_wstrb    = {NUM_M{wStrb_q}};
  assign m_axi_wvalid   = mWValid_q;
  assign m_axi_bready   = mBReady_q;
  assign m_axi_araddr   = {NUM_M{arAddr_q}};
  assign m_axi_arvalid  = mArValid_q;
  assign m_axi_rready   = mRReady_q;

endmodule
